uart_word_rx: RTL
=================

// Module: uart_word_rx
// PURPOSE
//  Parametrised UART receiver that assembles ceil(DATA_W/8) serial bytes into one DATA_W-bit word.
//  Sits between FTDI_BDBUS_0 (host RX pin) and the encoder datapath; replaces the fixed-format byte RX.
//  Adds optional parity, framing/parity error reporting, an inter-byte timeout and a valid/ready word output.
// PARAMETERS
//  CLK_HZ        4_000_000  system clock frequency (Hz)
//  BAUD          57_600     line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer, 69 at defaults)
//  DATA_W        17         output word width (the codec k); NBYTES = (DATA_W+7)/8
//  PARITY        0          0 none, 1 even, 2 odd (one parity bit after D7 when non-zero)
//  TIMEOUT_BITS  40         idle bit-times between bytes that abort a partial word
// PORTS
//  M_CLK_OSC    in   1       system clock, all logic on rising edge
//  M_RESET_B    in   1       asynchronous active-low reset
//  rx           in   1       serial input, idle high, asynchronous to M_CLK_OSC
//  word_data    out  DATA_W  assembled word, stable while word_valid=1
//  word_valid   out  1       word available; held until accepted
//  word_ready   in   1       consumer accept; transfer when word_valid&&word_ready
//  frame_err    out  1       1-cycle pulse: stop bit sampled 0
//  parity_err   out  1       1-cycle pulse: parity mismatch
//  timeout_err  out  1       1-cycle pulse: partial word discarded on idle timeout
//  overrun_err  out  1       1-cycle pulse: word completed while previous word not accepted
// BEHAVIOUR
//  Reset: all outputs 0, word_data=0, byte index 0, FSM IDLE, synchroniser flops=1. Reset mid-frame aborts all.
//  rx passes a 2-flop synchroniser; all sampling uses the synchronised value (2-cycle input latency).
//  Byte FSM: IDLE -> START on falling edge; START waits CLKS_PER_BIT/2, rx still 0 -> DATA else IDLE (glitch reject).
//   DATA samples 8 bits LSB-first every CLKS_PER_BIT; -> PARITY if PARITY!=0 else STOP; PARITY samples 1 bit.
//   STOP samples at mid-bit: 1 -> byte good; 0 -> frame_err. Then -> IDLE (re-arm on next falling edge, no wait for stop end).
//  Parity: even => XOR(data,parity)=0; odd => =1. Mismatch -> parity_err, byte bad. Frame error has priority (one pulse only).
//  Bad byte: discard it AND the partial word; byte index -> 0.
//  Assembly: little-endian; byte i fills word bits [8i+7:8i]; bits above DATA_W-1 in last byte ignored.
//  Timeout: counter runs while byte index!=0 and FSM IDLE; reaching TIMEOUT_BITS*CLKS_PER_BIT -> timeout_err, index 0.
//   Counter cleared on every start-bit detect.
//  Word complete (last good byte's stop sample): if !word_valid or (word_valid&&word_ready same cycle) ->
//   word_data loaded, word_valid=1 next cycle; else overrun_err, new word dropped, held word unchanged.
//  word_valid drops the cycle after a handshake; word_data holds last value.
//  Latency: word_valid rises 1 cycle after mid-stop-bit sample of final byte.
//  Widths: bit counter 3b, clk counter $clog2(CLKS_PER_BIT)+1, timeout counter $clog2(TIMEOUT_BITS*CLKS_PER_BIT)+1.
// STRUCTURE
//  uart_pkg: parity mode localparams (PAR_NONE/PAR_EVEN/PAR_ODD), FSM state encoding, CLKS_PER_BIT function.
//  Sub-module uart_rx_byte: synchroniser + byte FSM + parity/stop check; outputs byte, byte_ok pulse, err pulses.
//  Top uart_word_rx: byte index, shift/assembly register, timeout counter, valid/ready output register.
// TESTING (4 MHz clock, 57600 baud, 17361 ns bit, DATA_W=17 unless noted)
//  1 reset, send 00,00,00 -> one word_valid, word_data=17'h00000, no error pulses.
//  2 send 34,12,FF (word_ready=1) -> word_data=17'h11234; upper 7 bits of 0xFF ignored.
//  3 PARITY=1: send 0x01 with parity bit 0 -> parity_err pulse, no word; next 3 good bytes -> correct word.
//  4 send 34,12 then idle 40 bit-times -> timeout_err pulse; then 01,00,00 -> word_data=17'h00001.
//  5 word_ready=0, send two full words -> first held, overrun_err once, word_data still first word.
//  6 rx low pulse of 20 clocks -> ignored; stop bit forced 0 -> frame_err; M_RESET_B low mid-byte -> all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART word receiver: parity modes, byte FSM states, bit-timing helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: input synchroniser, start/data/parity/stop FSM and per-byte status strobes.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 69,
    parameter int unsigned PARITY       = PAR_NONE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       idle_c,
    output logic       start_c,
    output logic       byte_ok_c,
    output logic       frame_err_c,
    output logic       parity_err_c
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic        PAR_ON   = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
    localparam logic        PAR_ODDM = (PARITY == PAR_ODD);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_e        state;
    rx_state_e        state_d;
    logic [CNT_W-1:0] clk_cnt;
    logic [CNT_W-1:0] clk_cnt_d;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_cnt_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             par_q;
    logic             par_d;
    logic             par_bad_c;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_d;
            clk_cnt <= clk_cnt_d;
            bit_cnt <= bit_cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

    assign par_bad_c = (^{shift_q, par_q}) != PAR_ODDM;
    assign byte_data = shift_q;
    assign idle_c    = (state == ST_IDLE);

    always_comb begin
        state_d      = state;
        clk_cnt_d    = clk_cnt + CNT_W'(1);
        bit_cnt_d    = bit_cnt;
        shift_d      = shift_q;
        par_d        = par_q;
        start_c      = 1'b0;
        byte_ok_c    = 1'b0;
        frame_err_c  = 1'b0;
        parity_err_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (rx_prev && !rx_sync) begin
                    state_d = ST_START;
                    start_c = 1'b1;
                end
            end
            ST_START: begin
                // Half-bit recheck rejects glitches shorter than half a bit
                if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync, shift_q[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = PAR_ON ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    par_d     = rx_sync;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                // Framing error outranks parity error so a bad byte yields one pulse
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_d = '0;
                    state_d   = ST_IDLE;
                    if (!rx_sync) begin
                        frame_err_c = 1'b1;
                    end else if (PAR_ON && par_bad_c) begin
                        parity_err_c = 1'b1;
                    end else begin
                        byte_ok_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: packs little-endian serial bytes into DATA_W-bit words behind a valid/ready port.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 4_000_000,
    parameter int unsigned BAUD         = 57_600,
    parameter int unsigned DATA_W       = 17,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic              M_CLK_OSC,
    input  logic              M_RESET_B,
    input  logic              rx,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int unsigned CPB      = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned NBYTES   = (DATA_W + 7) / 8;
    localparam int unsigned IDX_W    = $clog2(NBYTES) + 1;
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT) + 1;

    logic [7:0]        byte_data;
    logic              idle_c;
    logic              start_c;
    logic              byte_ok_c;
    logic              frame_err_c;
    logic              parity_err_c;
    logic [IDX_W-1:0]  byte_idx;
    logic [DATA_W-1:0] asm_q;
    logic [DATA_W-1:0] word_next_c;
    logic [TO_W-1:0]   to_cnt;
    logic              last_byte_c;
    logic              word_done_c;
    logic              accept_c;
    logic              to_hit_c;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .PARITY       (PARITY)
    ) u_rx_byte (
        .clk          (M_CLK_OSC),
        .rst_n        (M_RESET_B),
        .rx           (rx),
        .byte_data    (byte_data),
        .idle_c       (idle_c),
        .start_c      (start_c),
        .byte_ok_c    (byte_ok_c),
        .frame_err_c  (frame_err_c),
        .parity_err_c (parity_err_c)
    );

    // Drop the incoming byte into its lane; bits past DATA_W-1 never exist
    for (genvar j = 0; j < DATA_W; j++) begin : g_merge
        assign word_next_c[j] = (byte_idx == IDX_W'(j / 8)) ? byte_data[j % 8] : asm_q[j];
    end

    assign last_byte_c = (byte_idx == IDX_W'(NBYTES - 1));
    assign word_done_c = byte_ok_c && last_byte_c;
    assign accept_c    = !word_valid || word_ready;
    assign to_hit_c    = idle_c && (byte_idx != '0) && (to_cnt == TO_W'(TO_LIMIT - 1));

    // Byte index and partial-word assembly; any bad byte or timeout restarts the word
    always_ff @(posedge M_CLK_OSC or negedge M_RESET_B) begin
        if (!M_RESET_B) begin
            byte_idx <= '0;
            asm_q    <= '0;
        end else if (frame_err_c || parity_err_c || to_hit_c) begin
            byte_idx <= '0;
        end else if (byte_ok_c) begin
            if (last_byte_c) begin
                byte_idx <= '0;
            end else begin
                byte_idx <= byte_idx + IDX_W'(1);
                asm_q    <= word_next_c;
            end
        end
    end

    // Inter-byte idle timer, only meaningful with a partial word pending
    always_ff @(posedge M_CLK_OSC or negedge M_RESET_B) begin
        if (!M_RESET_B) begin
            to_cnt <= '0;
        end else if (start_c || (byte_idx == '0) || to_hit_c) begin
            to_cnt <= '0;
        end else if (idle_c) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge M_CLK_OSC or negedge M_RESET_B) begin
        if (!M_RESET_B) begin
            word_data   <= '0;
            word_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_err_c;
            parity_err  <= parity_err_c;
            timeout_err <= to_hit_c;
            overrun_err <= word_done_c && !accept_c;
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (word_done_c && accept_c) begin
                word_valid <= 1'b1;
                word_data  <= word_next_c;
            end
        end
    end

endmodule
